// File: rtl/startup_sequencer.sv
// Startup sequencer: validates hierarchy enables for the latched startup type, launches the
// required startup clients (all at once or one at a time) and collects their done flags under a timeout.
module startup_sequencer #(
  parameter int                  NUM_SUBS     = 5,
  parameter bit                  ORDERED      = 1'b0,
  parameter int                  TIMEOUT_W    = 16,
  parameter int                  TIMEOUT_CYC  = 50000,
  parameter logic [NUM_SUBS-1:0] MASK_RESET   = '1,
  parameter logic [NUM_SUBS-1:0] MASK_RESTART = '1,
  parameter logic [NUM_SUBS-1:0] MASK_RESUME  = '1,
  localparam int                 IDX_W        = (NUM_SUBS > 1) ? $clog2(NUM_SUBS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [2:0]          op_state,
  input  logic [2:0]          startup_type,
  input  logic                phEnable,
  input  logic                shEnable,
  input  logic                ehEnable,
  input  logic                phEnableNV,
  input  logic                nv_shEnable,
  input  logic                nv_ehEnable,
  input  logic                nv_phEnableNV,
  input  logic [NUM_SUBS-1:0] sub_done,
  output logic [NUM_SUBS-1:0] sub_start,
  output logic [2:0]          startup_type_out,
  output logic                busy,
  output logic                startup_done,
  output logic                startup_fail,
  output logic [1:0]          fail_code,
  output logic [IDX_W-1:0]    fail_index
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_LAUNCH, ST_WAIT, ST_DONE, ST_FAIL
  } state_t;

  localparam logic [2:0] STARTUP_STATE = 3'b010;
  localparam logic [2:0] T_RESET       = 3'd1;
  localparam logic [2:0] T_RESTART     = 3'd2;
  localparam logic [2:0] T_RESUME      = 3'd3;

  localparam logic [1:0] CODE_HIER    = 2'd1;
  localparam logic [1:0] CODE_TYPE    = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  localparam bit                   TIMEOUT_EN = (TIMEOUT_CYC > 0);
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t                state;
  logic [NUM_SUBS-1:0]   pending;
  logic [NUM_SUBS-1:0]   target;
  logic [NUM_SUBS-1:0]   done_seen;
  logic [TIMEOUT_W-1:0]  timer;

  logic                  in_startup;
  logic [NUM_SUBS-1:0]   seen_now;
  logic                  complete;
  logic                  timed_out;
  logic [NUM_SUBS-1:0]   pending_left;
  logic [NUM_SUBS-1:0]   type_mask;
  logic                  hier_bad;
  logic                  type_bad;

  function automatic logic [NUM_SUBS-1:0] lowest_onehot(input logic [NUM_SUBS-1:0] v);
    return v & (~v + NUM_SUBS'(1));
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_SUBS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SUBS - 1; i >= 0; i--)
      if (v[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  // Parallel mode launches the whole pending set; ordered mode only its lowest member.
  function automatic logic [NUM_SUBS-1:0] launch_set(input logic [NUM_SUBS-1:0] v);
    return ORDERED ? lowest_onehot(v) : v;
  endfunction

  assign in_startup   = (op_state == STARTUP_STATE);
  assign seen_now     = done_seen | (sub_done & target);
  assign complete     = (seen_now == target);
  assign timed_out    = TIMEOUT_EN && (timer == TIMER_LAST);
  assign pending_left = pending & ~target;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    type_mask = '0;
    hier_bad  = !phEnable;
    type_bad  = 1'b0;
    case (startup_type_out)
      T_RESET: begin
        type_mask = MASK_RESET;
        hier_bad  = hier_bad || !(shEnable && ehEnable && phEnableNV);
      end
      T_RESTART: begin
        type_mask = MASK_RESTART;
        hier_bad  = hier_bad || !(shEnable && ehEnable && phEnableNV);
      end
      T_RESUME: begin
        type_mask = MASK_RESUME;
        hier_bad  = hier_bad || (shEnable != nv_shEnable) || (ehEnable != nv_ehEnable)
                    || (phEnableNV != nv_phEnableNV);
      end
      default: type_bad = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  // NOTE: the datapath registers are reset too; they are few and it keeps the reset state fully defined.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      pending          <= '0;
      target           <= '0;
      done_seen        <= '0;
      timer            <= '0;
      sub_start        <= '0;
      startup_type_out <= '0;
      busy             <= 1'b0;
      startup_done     <= 1'b0;
      startup_fail     <= 1'b0;
      fail_code        <= '0;
      fail_index       <= '0;
    end else begin
      sub_start <= '0;
      if (state != ST_IDLE && !in_startup) begin
        state            <= ST_IDLE;
        startup_type_out <= '0;
        busy             <= 1'b0;
        startup_done     <= 1'b0;
        startup_fail     <= 1'b0;
        fail_code        <= '0;
        fail_index       <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (in_startup) begin
              state            <= ST_CHECK;
              startup_type_out <= startup_type;
              busy             <= 1'b1;
            end
          end
          ST_CHECK: begin
            if (hier_bad || type_bad) begin
              state        <= ST_FAIL;
              busy         <= 1'b0;
              startup_fail <= 1'b1;
              fail_code    <= hier_bad ? CODE_HIER : CODE_TYPE;
              fail_index   <= '0;
            end else if (type_mask == '0) begin
              state        <= ST_DONE;
              busy         <= 1'b0;
              startup_done <= 1'b1;
            end else begin
              state     <= ST_LAUNCH;
              pending   <= type_mask;
              target    <= launch_set(type_mask);
              sub_start <= launch_set(type_mask);
            end
          end
          ST_LAUNCH: begin
            state     <= ST_WAIT;
            timer     <= '0;
            done_seen <= '0;
          end
          ST_WAIT: begin
            done_seen <= seen_now;
            timer     <= timer + TIMEOUT_W'(1);
            if (complete) begin
              if (pending_left != '0) begin
                state     <= ST_LAUNCH;
                pending   <= pending_left;
                target    <= launch_set(pending_left);
                sub_start <= launch_set(pending_left);
              end else begin
                state        <= ST_DONE;
                pending      <= '0;
                busy         <= 1'b0;
                startup_done <= 1'b1;
              end
            end else if (timed_out) begin
              state        <= ST_FAIL;
              busy         <= 1'b0;
              startup_fail <= 1'b1;
              fail_code    <= CODE_TIMEOUT;
              fail_index   <= lowest_idx(target & ~done_seen);
            end
          end
          ST_DONE, ST_FAIL: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_startup_sequencer.sv
// Directed bench for startup_sequencer: a parallel instance and an ordered instance share the
// control inputs and have separate client done lines; all expected values are hand-computed.
module tb_startup_sequencer;

  localparam int N  = 5;
  localparam int IW = 3;

  localparam logic [2:0] STARTUP = 3'b010;
  localparam logic [2:0] OPER    = 3'b011;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic [2:0]   op_state, startup_type;
  logic         ph_en, sh_en, eh_en, phnv_en, nv_sh, nv_eh, nv_phnv;
  logic [N-1:0] sd_p, sd_o, start_p, start_o;
  logic [2:0]   type_p, type_o;
  logic         busy_p, done_p, fail_p, busy_o, done_o, fail_o;
  logic [1:0]   code_p, code_o;
  logic [IW-1:0] idx_p, idx_o;
  logic [15:0]  outs_p, outs_o;

  assign outs_p = {start_p, type_p, busy_p, done_p, fail_p, code_p, idx_p};
  assign outs_o = {start_o, type_o, busy_o, done_o, fail_o, code_o, idx_o};

  startup_sequencer #(
    .NUM_SUBS(N), .ORDERED(1'b0), .TIMEOUT_W(16), .TIMEOUT_CYC(20)
  ) dut_par (
    .clock(clock), .reset_n(reset_n), .op_state(op_state), .startup_type(startup_type),
    .phEnable(ph_en), .shEnable(sh_en), .ehEnable(eh_en), .phEnableNV(phnv_en),
    .nv_shEnable(nv_sh), .nv_ehEnable(nv_eh), .nv_phEnableNV(nv_phnv),
    .sub_done(sd_p), .sub_start(start_p), .startup_type_out(type_p), .busy(busy_p),
    .startup_done(done_p), .startup_fail(fail_p), .fail_code(code_p), .fail_index(idx_p)
  );

  // Ordered instance: nothing required for RESET, clients 0/2/4 for RESUME.
  startup_sequencer #(
    .NUM_SUBS(N), .ORDERED(1'b1), .TIMEOUT_W(16), .TIMEOUT_CYC(20),
    .MASK_RESET(5'b00000), .MASK_RESUME(5'b10101)
  ) dut_ord (
    .clock(clock), .reset_n(reset_n), .op_state(op_state), .startup_type(startup_type),
    .phEnable(ph_en), .shEnable(sh_en), .ehEnable(eh_en), .phEnableNV(phnv_en),
    .nv_shEnable(nv_sh), .nv_ehEnable(nv_eh), .nv_phEnableNV(nv_phnv),
    .sub_done(sd_o), .sub_start(start_o), .startup_type_out(type_o), .busy(busy_o),
    .startup_done(done_o), .startup_fail(fail_o), .fail_code(code_o), .fail_index(idx_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Running tallies sampled on the falling edge; tests compare deltas.
  int           n_start_p = 0;
  int           n_start_o = 0;
  int           n_busy_p  = 0;
  logic [N-1:0] start_log_o[$];

  always @(negedge clock) begin
    if (start_p != '0) n_start_p++;
    if (start_o != '0) begin
      n_start_o++;
      start_log_o.push_back(start_o);
    end
    if (busy_p) n_busy_p++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_en(input logic ph, input logic sh, input logic eh, input logic phnv,
                        input logic nsh, input logic neh, input logic nphnv);
    ph_en = ph; sh_en = sh; eh_en = eh; phnv_en = phnv;
    nv_sh = nsh; nv_eh = neh; nv_phnv = nphnv;
  endtask

  task automatic go(input logic [2:0] t);
    op_state     = STARTUP;
    startup_type = t;
  endtask

  task automatic leave(input string tag);
    op_state = OPER;
    tick();
    check({tag, "_clear_p"}, 32'(outs_p), 32'h0);
    check({tag, "_clear_o"}, 32'(outs_o), 32'h0);
  endtask

  int nb, nbo, nbusy, qs;

  initial begin
    reset_n      = 1'b0;
    op_state     = 3'b000;
    startup_type = 3'd0;
    set_en(1, 1, 1, 1, 1, 1, 1);
    sd_p = '0;
    sd_o = '0;
    #3;
    check("reset_p", 32'(outs_p), 32'h0);
    check("reset_o", 32'(outs_o), 32'h0);
    #20 reset_n = 1'b1;
    tick();

    // 1: RESET, parallel, clients pulse done a few cycles after start.
    nb = n_start_p;
    go(3'd1);
    tick();
    check("t1_check_busy", 32'(busy_p), 32'h1);
    check("t1_type_latched", 32'(type_p), 32'h1);
    check("t1_no_start_in_check", 32'(start_p), 32'h0);
    tick();
    check("t1_launch", 32'(start_p), 32'h1F);
    check("t1_mask0_done_o", 32'({done_o, busy_o, fail_o}), 32'b100);
    tick();
    check("t1_start_pulse_once", 32'(start_p), 32'h0);
    tick();
    check("t1_waiting", 32'({busy_p, done_p}), 32'b10);
    sd_p = 5'h1F;
    tick();
    sd_p = '0;
    check("t1_done", 32'({busy_p, done_p, fail_p}), 32'b010);
    tick(3);
    check("t1_done_sticky", 32'(done_p), 32'h1);
    check("t1_start_count", 32'(n_start_p - nb), 32'd1);
    leave("t1");

    // 2: RESUME with sh != nv_sh -> hierarchy failure, no starts.
    nb  = n_start_p;
    nbo = n_start_o;
    set_en(1, 1, 1, 1, 0, 1, 1);
    go(3'd3);
    tick(2);
    check("t2_fail_p", 32'({done_p, fail_p, code_p, idx_p}), 32'({1'b0, 1'b1, 2'd1, 3'd0}));
    check("t2_fail_o", 32'({fail_o, code_o}), 32'({1'b1, 2'd1}));
    tick(2);
    check("t2_no_start_p", 32'(n_start_p - nb), 32'd0);
    check("t2_no_start_o", 32'(n_start_o - nbo), 32'd0);
    leave("t2");

    // 3: bad type, then hierarchy failure taking priority on RESTART.
    set_en(1, 1, 1, 1, 1, 1, 1);
    go(3'd4);
    tick(2);
    check("t3_bad_type", 32'({fail_p, code_p}), 32'({1'b1, 2'd2}));
    leave("t3a");
    set_en(0, 1, 1, 1, 1, 1, 1);
    go(3'd2);
    tick(2);
    check("t3_ph_priority", 32'({fail_p, code_p}), 32'({1'b1, 2'd1}));
    leave("t3b");

    // 4: timeout with client 3 silent, then completion on the last WAIT cycle.
    set_en(1, 1, 1, 1, 1, 1, 1);
    sd_p  = 5'b10111;
    nbusy = n_busy_p;
    go(3'd1);
    tick(22);
    check("t4_still_waiting", 32'({busy_p, fail_p}), 32'b10);
    tick();
    check("t4_timeout", 32'({busy_p, done_p, fail_p, code_p, idx_p}),
          32'({1'b0, 1'b0, 1'b1, 2'd3, 3'd3}));
    check("t4_busy_cycles", 32'(n_busy_p - nbusy), 32'd22);
    leave("t4a");
    go(3'd1);
    tick(22);
    sd_p = 5'h1F;
    tick();
    check("t4_last_cycle_done", 32'({done_p, fail_p}), 32'b10);
    sd_p = '0;
    leave("t4b");

    // 5: ordered RESUME over clients 0, 2, 4; early done from 4 is ignored.
    nbo = n_start_o;
    qs  = start_log_o.size();
    go(3'd3);
    tick(2);
    check("t5_start0", 32'(start_o), 32'b00001);
    tick();
    sd_o = 5'b10000;
    tick();
    sd_o = '0;
    check("t5_hold_for_0", 32'({start_o, busy_o}), 32'({5'b00000, 1'b1}));
    sd_o = 5'b00001;
    tick();
    sd_o = '0;
    check("t5_start2", 32'(start_o), 32'b00100);
    tick();
    sd_o = 5'b00100;
    tick();
    sd_o = '0;
    check("t5_start4", 32'(start_o), 32'b10000);
    tick(2);
    check("t5_early_done_ignored", 32'({busy_o, done_o}), 32'b10);
    sd_o = 5'b10000;
    tick();
    sd_o = '0;
    check("t5_done", 32'({done_o, fail_o}), 32'b10);
    check("t5_start_count", 32'(n_start_o - nbo), 32'd3);
    if (start_log_o.size() >= qs + 3) begin
      check("t5_order0", 32'(start_log_o[qs]),     32'b00001);
      check("t5_order1", 32'(start_log_o[qs + 1]), 32'b00100);
      check("t5_order2", 32'(start_log_o[qs + 2]), 32'b10000);
    end else begin
      check("t5_log_size", 32'(start_log_o.size() - qs), 32'd3);
    end
    leave("t5");

    // 6: abort mid-WAIT, abort during CHECK, clean re-entry, async reset.
    go(3'd1);
    tick(3);
    op_state = OPER;
    tick();
    check("t6_abort_wait_p", 32'(outs_p), 32'h0);
    check("t6_abort_wait_o", 32'(outs_o), 32'h0);
    nb = n_start_p;
    go(3'd1);
    tick();
    op_state = OPER;
    tick();
    check("t6_abort_check", 32'(outs_p), 32'h0);
    tick();
    check("t6_no_start_after_abort", 32'(n_start_p - nb), 32'd0);
    sd_p = 5'h1F;
    go(3'd2);
    tick(3);
    check("t6_reentry_pending", 32'({type_p, done_p}), 32'({3'd2, 1'b0}));
    tick();
    check("t6_latency4_done", 32'({done_p, fail_p}), 32'b10);
    sd_p = '0;
    leave("t6a");
    go(3'd1);
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_reset_p", 32'(outs_p), 32'h0);
    check("t6_async_reset_o", 32'(outs_o), 32'h0);
    #2 reset_n = 1'b1;
    tick();
    check("t6_restart_after_reset", 32'({busy_p, type_p}), 32'({1'b1, 3'd1}));
    leave("t6b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
